// File: rtl/lift_xfer_cntrl.sv
// lift_xfer_cntrl: sequences one ibuff write or obuff read burst per start, with host flow control and read-latency drain
module lift_xfer_cntrl #(
  parameter int ADDR_W        = 4,
  parameter int SMALL_WR_LAST = 5,
  parameter int LARGE_WR_LAST = 12,
  parameter int SMALL_RD_LAST = 6,
  parameter int LARGE_RD_LAST = 5,
  parameter int RD_LAT        = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              lift_mode,
  input  logic              read_write,
  input  logic              in_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] ext_addr,
  output logic              ext_we,
  output logic              ext_re,
  output logic              result_valid,
  output logic              ext_we_done,
  output logic              busy,
  output logic              done
);
  localparam int CW = RD_LAT < 2 ? 1 : $clog2(RD_LAT + 1);
  if (SMALL_WR_LAST >= 2**ADDR_W || LARGE_WR_LAST >= 2**ADDR_W ||
      SMALL_RD_LAST >= 2**ADDR_W || LARGE_RD_LAST >= 2**ADDR_W || RD_LAT < 1) begin : g_bad_cfg
    $error("lift_xfer_cntrl: LAST parameter does not fit ADDR_W or RD_LAT < 1");
  end
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t            state;
  logic [ADDR_W-1:0] last;
  logic              rw;
  logic [CW-1:0]     cnt;
  logic [RD_LAT-1:0] rv_sr;
  logic              at_last;
  always_comb begin
    at_last      = ext_addr == last;
    ext_we       = state == RUN && !rw && in_valid;
    ext_re       = state == RUN && rw && out_ready;
    ext_we_done  = ext_we && at_last;
    busy         = state != IDLE;
    done         = state == DONE;
    result_valid = rv_sr[RD_LAT-1];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ext_addr <= '0;
      last     <= '0;
      rw       <= 1'b0;
      cnt      <= '0;
      rv_sr    <= '0;
    end else begin
      // every issued read returns data RD_LAT cycles later, independent of out_ready
      rv_sr[0] <= ext_re;
      for (int i = 1; i < RD_LAT; i++) rv_sr[i] <= rv_sr[i-1];
      case (state)
        IDLE: if (start) begin
          last     <= lift_mode ? (read_write ? ADDR_W'(LARGE_RD_LAST) : ADDR_W'(LARGE_WR_LAST))
                                : (read_write ? ADDR_W'(SMALL_RD_LAST) : ADDR_W'(SMALL_WR_LAST));
          rw       <= read_write;
          ext_addr <= '0;
          state    <= RUN;
        end
        RUN: if (ext_we || ext_re) begin
          if (at_last) begin
            state <= rw ? DRAIN : DONE;
            cnt   <= CW'(RD_LAT);
          end else ext_addr <= ext_addr + 1'b1;
        end
        DRAIN: begin
          cnt   <= cnt - 1'b1;
          state <= cnt == CW'(1) ? DONE : DRAIN;
        end
        default: begin
          ext_addr <= '0;
          state    <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_lift_xfer_cntrl.sv
// tb_lift_xfer_cntrl: directed bursts with per-cycle output masks compared against hand-computed values
module tb_lift_xfer_cntrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       lift_mode = 1'b0;
  logic       read_write = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [3:0] ext_addr;
  logic       ext_we, ext_re, result_valid, ext_we_done, busy, done;
  int         n_tests = 0;
  int         n_fail = 0;
  logic [63:0] we_m, re_m, rv_m, wd_m, busy_m, done_m, trace;
  logic [3:0]  addr_hist [64];

  lift_xfer_cntrl dut (
    .clk(clk), .rst(rst), .start(start), .lift_mode(lift_mode), .read_write(read_write),
    .in_valid(in_valid), .out_ready(out_ready), .ext_addr(ext_addr), .ext_we(ext_we),
    .ext_re(ext_re), .result_valid(result_valid), .ext_we_done(ext_we_done),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // bit k of each mask is the input/output value during cycle k after the call
  task automatic run(input int n, input logic [63:0] st, input logic [63:0] iv, input logic [63:0] ordy,
                     input logic [63:0] lm, input logic [63:0] rwm, input logic [63:0] rsm);
    we_m = '0; re_m = '0; rv_m = '0; wd_m = '0; busy_m = '0; done_m = '0; trace = '0;
    for (int k = 0; k < n; k++) begin
      start = st[k]; in_valid = iv[k]; out_ready = ordy[k];
      lift_mode = lm[k]; read_write = rwm[k]; rst = rsm[k];
      #1;
      we_m[k] = ext_we; re_m[k] = ext_re; rv_m[k] = result_valid;
      wd_m[k] = ext_we_done; busy_m[k] = busy; done_m[k] = done;
      addr_hist[k] = ext_addr;
      if (ext_we || ext_re) trace = {trace[59:0], ext_addr};
      @(posedge clk);
      #1;
    end
    start = 0; in_valid = 0; out_ready = 0; lift_mode = 0; read_write = 0; rst = 0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    #1;
    check("rst_addr", 64'(ext_addr), 0);
    check("rst_we", 64'(ext_we), 0);
    check("rst_re", 64'(ext_re), 0);
    check("rst_rv", 64'(result_valid), 0);
    check("rst_wd", 64'(ext_we_done), 0);
    check("rst_busy", 64'(busy), 0);
    check("rst_done", 64'(done), 0);
    @(posedge clk);
    #1;
    // small write, no stalls
    run(10, 64'h1, '1, '0, '0, '0, '0);
    check("sw_we", we_m, 64'h7E);
    check("sw_addr", trace, 64'h012345);
    check("sw_wd", wd_m, 64'h40);
    check("sw_done", done_m, 64'h80);
    check("sw_busy", busy_m, 64'hFE);
    check("sw_re", re_m | rv_m, 0);
    // large read, no stalls
    run(12, 64'h1, '0, '1, '1, '1, '0);
    check("lr_re", re_m, 64'h7E);
    check("lr_addr", trace, 64'h012345);
    check("lr_rv", rv_m, 64'h1F8);
    check("lr_done", done_m, 64'h200);
    check("lr_busy", busy_m, 64'h3FE);
    check("lr_we", we_m | wd_m, 0);
    // large write, in_valid low for two cycles while addr=3
    run(20, 64'h1, ~64'h30, '0, '1, '0, '0);
    check("lw_we", we_m, 64'hFFCE);
    check("lw_addr", trace, 64'h0123456789ABC);
    check("lw_hold4", 64'(addr_hist[4]), 3);
    check("lw_hold5", 64'(addr_hist[5]), 3);
    check("lw_wd", wd_m, 64'h8000);
    check("lw_done", done_m, 64'h10000);
    // small read, out_ready toggling
    run(20, 64'h1, '0, 64'hAAAAAAAAAAAAAAAA, '0, '1, '0);
    check("sr_re", re_m, 64'h2AAA);
    check("sr_addr", trace, 64'h0123456);
    check("sr_rv", rv_m, 64'hAAA8);
    check("sr_done", done_m, 64'h10000);
    // stray starts mid-burst and in DONE, mode/direction flipping mid-burst
    run(10, 64'h89, '1, '1, 64'h1FC, 64'h1FC, '0);
    check("ig_we", we_m, 64'h7E);
    check("ig_re", re_m, 0);
    check("ig_done", done_m, 64'h80);
    check("ig_busy", busy_m, 64'hFE);
    // reset during a large read
    run(10, 64'h1, '0, '1, '1, '1, 64'h10);
    check("rs_re", re_m, 64'h1E);
    check("rs_rv", rv_m, 64'h18);
    check("rs_busy", busy_m, 64'h1E);
    check("rs_done", done_m, 0);
    check("rs_addr5", 64'(addr_hist[5]), 0);
    // a fresh burst after the reset completes normally
    run(10, 64'h1, '1, '0, '0, '0, '0);
    check("ar_we", we_m, 64'h7E);
    check("ar_done", done_m, 64'h80);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/lift_xfer_cntrl.md
# lift_xfer_cntrl

Parametrised transfer controller for the lift/Shoup unit's external buffers. It sequences the address, write-enable and read-enable for one burst per `start`, writing into the input buffer or reading out of the output buffer. Burst lengths are selectable per mode and direction. Host-side flow control is supported: `in_valid` gates writes and `out_ready` gates reads. A configurable read pipeline latency is tracked so that `result_valid` and `done` line up with the last datum.

## Interface
- `ADDR_W`, 4, width of `ext_addr`
- `SMALL_WR_LAST`, 5, last address of a small-mode ibuff write (6 words)
- `LARGE_WR_LAST`, 12, last address of a large-mode ibuff write (13 words)
- `SMALL_RD_LAST`, 6, last address of a small-mode obuff read (7 words)
- `LARGE_RD_LAST`, 5, last address of a large-mode obuff read (6 words)
- `RD_LAT`, 2, obuff read latency in cycles, from `ext_re` to data; must be ≥1
- All `*_LAST` values must be < 2^ADDR_W (elaboration-time check)

Ports:
- `clk` in 1: single clock, rising edge
- `rst` in 1: synchronous, active-high reset
- `start` in 1: one-cycle request; sampled only in IDLE
- `lift_mode` in 1: 0 = small, 1 = large; latched on accepted `start`
- `read_write` in 1: 1 = obuff read, 0 = ibuff write; latched on accepted `start`
- `in_valid` in 1: write data present this cycle
- `out_ready` in 1: consumer can accept a read issued this cycle
- `ext_addr` out ADDR_W: buffer address (registered)
- `ext_we` out 1: ibuff write strobe
- `ext_re` out 1: obuff read strobe
- `result_valid` out 1: obuff data valid, `ext_re` delayed by RD_LAT
- `ext_we_done` out 1: pulses with the final write
- `busy` out 1: high in every state except IDLE
- `done` out 1: one-cycle completion pulse

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- **IDLE:**
  - `start`=1 latches `lift_mode` and `read_write`, selects LAST from the four parameters, clears `ext_addr` to 0, then goes to RUN.
  - `start`=0: stay in IDLE.
- **RUN, write (`read_write`=0):**
  - `ext_we` = `in_valid`.
  - On `in_valid`: if `ext_addr`==LAST, assert `ext_we_done` and go to DONE; otherwise increment `ext_addr`.
  - `in_valid`=0: hold `ext_addr`, no strobe.
- **RUN, read (`read_write`=1):**
  - `ext_re` = `out_ready`.
  - On `out_ready`: if `ext_addr`==LAST, go to DRAIN with the drain counter set to RD_LAT; otherwise increment `ext_addr`.
  - `out_ready` gates issue only. Every issued read returns data RD_LAT cycles later regardless of `out_ready`.
- **DRAIN:** decrement the drain counter each cycle; go to DONE when it reaches 1. No strobes are driven.
- **DONE:** `done`=1 for one cycle, `ext_addr` returns to 0, then go to IDLE.
- `result_valid` comes from an RD_LAT-deep shift register fed by `ext_re`. The register is cleared by `rst`.
- `start` outside IDLE is ignored, including in the DONE cycle. Inputs latched at start are not re-sampled mid-burst.
- `ext_addr` never exceeds LAST, so no wrap occurs.
- `rst` at any time: FSM to IDLE, all registers cleared, in-flight reads discarded, no `done` pulse.

## Timing
- Reset values: `ext_addr`=0, `ext_we`=0, `ext_re`=0, `result_valid`=0, `ext_we_done`=0, `busy`=0, `done`=0.
- `start` accepted at cycle t: `busy`=1 and the first strobe is possible at t+1 with `ext_addr`=0.
- `ext_we`, `ext_re` and `ext_we_done` are combinational from state and `in_valid`/`out_ready`. `ext_addr` is registered.
- Write burst with no stalls: strobes at t+1 … t+LAST+1, `done` at t+LAST+2.
- Read burst with no stalls: `ext_re` at t+1 … t+LAST+1, `result_valid` at t+1+RD_LAT … t+LAST+1+RD_LAT, `done` at t+LAST+2+RD_LAT.
- Each stall cycle delays all later events by exactly one cycle.
- Earliest next `start` acceptance is the cycle after `done`.

## Test plan
- Small write, `in_valid`=1, start at cycle 0 -> `ext_we` cycles 1–6 with addr 0–5; `ext_we_done` at 6; `done` at 7; `busy` 1–7.
- Large read, `out_ready`=1, RD_LAT=2, start at 0 -> `ext_re` cycles 1–6 with addr 0–5; `result_valid` 3–8; `done` at 9; `ext_we`=0 throughout.
- Large write with `in_valid`=0 for 2 cycles while addr=3 -> addr holds 3, `ext_we`=0 for those cycles; 13 writes total; `done` at cycle 16.
- Small read with `out_ready` toggling 1,0,1,0… -> exactly 7 `ext_re`; `result_valid` pattern equals the `ext_re` pattern shifted by 2; `done` 3 cycles after the last `ext_re`.
- `start` pulsed at cycles 3 and 7 (DONE) of a small write -> ignored; `lift_mode`/`read_write` changes mid-burst have no effect.
- `rst` at cycle 4 of a read -> next cycle: all outputs 0, `result_valid` 0, no `done`; a new start then completes normally.
